// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand selection.
// Optional macro FORWARDING_EN adds MEM/WB operand forwarding; without it the forwarding ports are ignored.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        ValidIn,
  input  logic [31:0] DatoA,
  input  logic [31:0] DatoB,
  input  logic [31:0] Inmediato,
  input  logic        UsaInm,
  input  logic [2:0]  AluOpIn,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic        EscribeRegIn,
  input  logic        LeeMemIn,
  input  logic [31:0] ResultadoMem,
  input  logic [31:0] DatoWb,
  input  logic [4:0]  RdMem,
  input  logic [4:0]  RdWb,
  input  logic        EscribeRegMem,
  input  logic        EscribeRegWb,
  output logic [31:0] Ope1,
  output logic [31:0] Ope2,
  output logic [2:0]  AluOp,
  output logic [4:0]  RdEx,
  output logic        EscribeRegEx,
  output logic        LeeMemEx,
  output logic        ValidEx,
  output logic        HazardReq
);

  typedef struct packed {
    logic        valid;
    logic        escribe_reg;
    logic        lee_mem;
    logic        usa_inm;
    logic [2:0]  alu_op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] dato_a;
    logic [31:0] dato_b;
    logic [31:0] inmediato;
  } stage_t;

  stage_t stage_reg;
  stage_t stage_next;
  logic   hazard;

  // Load in EX whose destination is read by the instruction now in decode.
  assign hazard = ValidIn && stage_reg.valid && stage_reg.lee_mem && (stage_reg.rd != 5'd0) &&
                  ((stage_reg.rd == Rs) || ((stage_reg.rd == Rt) && !UsaInm));

  always_comb begin
    stage_next = stage_reg;
    if (Flush) begin
      stage_next = '0;
    end else if (Stall) begin
      stage_next = stage_reg;
    end else if (hazard) begin
      stage_next = '0;
    end else begin
      stage_next.valid       = ValidIn;
      stage_next.escribe_reg = EscribeRegIn;
      stage_next.lee_mem     = LeeMemIn;
      stage_next.usa_inm     = UsaInm;
      stage_next.alu_op      = AluOpIn;
      stage_next.rs          = Rs;
      stage_next.rt          = Rt;
      stage_next.rd          = Rd;
      stage_next.dato_a      = DatoA;
      stage_next.dato_b      = DatoB;
      stage_next.inmediato   = Inmediato;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Operand 0 feeds Ope1 (Rs), operand 1 feeds Ope2 (Rt) before the immediate mux.
  logic [4:0]  opnd_src [2];
  logic [31:0] opnd_reg [2];
  logic [31:0] opnd_sel [2];

  assign opnd_src[0] = stage_reg.rs;
  assign opnd_src[1] = stage_reg.rt;
  assign opnd_reg[0] = stage_reg.dato_a;
  assign opnd_reg[1] = stage_reg.dato_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
`ifdef FORWARDING_EN
      logic hit_mem;
      logic hit_wb;
      // Register 0 is hard-wired, so it is never a forwarding match; MEM is younger and wins.
      assign hit_mem = EscribeRegMem && (RdMem != 5'd0) && (RdMem == opnd_src[gi]);
      assign hit_wb  = EscribeRegWb  && (RdWb  != 5'd0) && (RdWb  == opnd_src[gi]);
      assign opnd_sel[gi] = hit_mem ? ResultadoMem :
                            hit_wb  ? DatoWb       : opnd_reg[gi];
`else
      assign opnd_sel[gi] = opnd_reg[gi];
`endif
    end
  endgenerate

`ifndef FORWARDING_EN
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ResultadoMem, DatoWb, RdMem, RdWb, EscribeRegMem, EscribeRegWb,
                               opnd_src[0], opnd_src[1]};
`endif

  assign Ope1         = opnd_sel[0];
  assign Ope2         = stage_reg.usa_inm ? stage_reg.inmediato : opnd_sel[1];
  assign AluOp        = stage_reg.alu_op;
  assign RdEx         = stage_reg.rd;
  assign EscribeRegEx = stage_reg.escribe_reg;
  assign LeeMemEx     = stage_reg.lee_mem;
  assign ValidEx      = stage_reg.valid;
  assign HazardReq    = hazard;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and reset.
REQ-002 clk  in  1  pipeline clock.
REQ-003 reset  in  1  asynchronous, active-high; clears all stage registers.
REQ-004 Stall  in  1  hold all stage registers.
REQ-005 Flush  in  1  load a bubble.
REQ-006 ValidIn  in  1  decode stage presents a valid instruction.
REQ-007 DatoA, DatoB, Inmediato  in  32 each  register-file read values and sign-extended immediate.
REQ-008 UsaInm  in  1  select Inmediato instead of DatoB for Ope2.
REQ-009 AluOpIn  in  3  ALU operation code, using the ALU encoding (010 ADD … 110 SLT).
REQ-010 Rs, Rt, Rd  in  5 each  source and destination register numbers.
REQ-011 EscribeRegIn, LeeMemIn  in  1 each  register-write and load flags.
REQ-012 ResultadoMem, DatoWb  in  32 each  forwarding sources from the MEM and WB stages.
REQ-013 RdMem, RdWb  in  5 each; EscribeRegMem, EscribeRegWb  in  1 each  forwarding tags.
REQ-014 Ope1, Ope2  out  32 each  ALU operands.
REQ-015 AluOp  out  3  registered AluOpIn.
REQ-016 RdEx  out  5; EscribeRegEx, LeeMemEx, ValidEx  out  1 each  registered control.
REQ-017 HazardReq  out  1  load-use stall request to fetch and decode.

Function
REQ-018 HazardReq SHALL be combinational: ValidIn & ValidEx & LeeMemEx & RdEx≠0 & (RdEx==Rs | (RdEx==Rt & !UsaInm)).
REQ-019 Edge priority SHALL be: Flush → bubble; else Stall → hold; else HazardReq → bubble; else capture all inputs, with ValidEx=ValidIn.
REQ-020 A bubble SHALL clear ValidEx, EscribeRegEx and LeeMemEx to 0, and clear all other stage registers to 0.
REQ-021 The stage SHALL register DatoA, DatoB, Inmediato, UsaInm, Rs, Rt, Rd and AluOpIn; latency from capture to Ope1, Ope2 and AluOp SHALL be 1 cycle.
REQ-022 Ope1 SHALL be combinational on the registered operand and the current forwarding inputs, and SHALL select:
- ResultadoMem if EscribeRegMem & RdMem≠0 & RdMem==Rs_reg;
- else DatoWb if EscribeRegWb & RdWb≠0 & RdWb==Rs_reg;
- else DatoA_reg.
REQ-023 Ope2 SHALL be Inmediato_reg when UsaInm_reg=1. Otherwise it SHALL use the REQ-022 rule with Rt_reg and DatoB_reg.
REQ-024 Register 0 SHALL never be forwarded. MEM SHALL win when MEM and WB both match.
REQ-025 Flush asserted together with Stall SHALL produce a bubble.

Reset
REQ-026 Reset SHALL act asynchronously and force the bubble state, so all registered outputs are 0.
REQ-027 While reset=1, HazardReq=0, and Ope1 and Ope2 SHALL be 0 unless forwarding inputs match register 0; they never match, because of REQ-024.
REQ-028 Reset deasserted mid-stall SHALL leave the stage empty; the first capture SHALL occur on the first edge with Stall=0.

Configuration
REQ-029 Macro FORWARDING_EN: when defined, REQ-022 to REQ-024 apply.
REQ-030 When FORWARDING_EN is undefined:
- Ope1 SHALL be DatoA_reg;
- Ope2 SHALL be UsaInm_reg ? Inmediato_reg : DatoB_reg;
- the forwarding ports SHALL remain present and be ignored;
- HazardReq behaviour SHALL be unchanged.

Verification
REQ-031 Capture: ValidIn=1, DatoA=5, DatoB=3, AluOpIn=011, Rs=1, Rt=2, no forwarding → after one edge Ope1=5, Ope2=3, AluOp=011, ValidEx=1.
REQ-032 Forwarding, with FORWARDING_EN defined:
- Rs_reg=4, RdMem=4, EscribeRegMem=1, ResultadoMem=0xAA, RdWb=4, EscribeRegWb=1, DatoWb=0xBB → Ope1=0xAA;
- the same with RdMem=0 → Ope1=0xBB.
REQ-033 Load-use: stage holds LeeMemEx=1, RdEx=7, and the incoming Rs=7 → HazardReq=1; the next edge yields ValidEx=0 and EscribeRegEx=0.
REQ-034 Stall/Flush:
- Stall=1 for 3 edges with changing inputs → outputs unchanged;
- Stall=1 with Flush=1 → ValidEx=0.
REQ-035 Reset asserted between edges with the stage full → all registered outputs become 0 immediately, with no clock edge.
